conv_out_packer: RTL and testbench



---
 rtl/conv_out_packer.sv | 118 +++++++++++
 tb/tb_conv_out_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_packer.sv
// conv_out_packer: saturate conv samples to 8-bit edge magnitudes, tag raster position, buffer in a FIFO
module conv_out_packer #(
  parameter int         OUTPUT_SIZE = 14,
  parameter int         IN_W        = 13,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] THRESH      = 8'd32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_pixel,
  output logic            out_edge,
  output logic            out_eol,
  output logic            out_eof,
  output logic            overflow,
  output logic            frame_done,
  output logic            busy
);
  localparam int CW = $clog2(OUTPUT_SIZE);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
  state_t state, state_next;
  logic nf, nf_next;
  logic [IN_W:0] ext, mag;
  logic [7:0] pix;
  logic [CW-1:0] col, row;
  logic in_eol, in_eof;
  logic a_valid;
  logic [10:0] a_entry, head, last;
  logic [10:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop;
  // one extra bit of width lets -2^(IN_W-1) negate to a positive magnitude
  assign ext    = {in_data[IN_W-1], in_data};
  assign mag    = ext[IN_W] ? (~ext + 1'b1) : ext;
  assign pix    = |mag[IN_W:8] ? 8'hFF : mag[7:0];
  assign in_eol = col == CW'(OUTPUT_SIZE - 1);
  assign in_eof = in_eol && row == CW'(OUTPUT_SIZE - 1);
  assign empty  = wr_ptr == rd_ptr;
  assign full   = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign pop    = out_valid && out_ready;
  assign push   = a_valid && (!full || pop);
  assign head   = mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;
  assign {out_pixel, out_edge, out_eol, out_eof} = empty ? last : head;
  assign busy = state != IDLE;
  // stage A register and raster counters; counters advance even when the sample is later dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid <= 1'b0;
      a_entry <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_entry <= {pix, pix >= THRESH, in_eol, in_eof};
        col     <= in_eol ? '0 : col + 1'b1;
        row     <= in_eof ? '0 : in_eol ? row + 1'b1 : row;
      end
    end
  end
  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= a_entry;
  end
  // FIFO pointers, held output fields while empty, sticky overflow and eof-pop pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last       <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= head;
      end
      if (a_valid && !push) overflow <= 1'b1;
      frame_done <= pop && head[0];
    end
  end
  // FSM state register plus the "next frame already started" flag used while flushing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      nf    <= 1'b0;
    end else begin
      state <= state_next;
      nf    <= nf_next;
    end
  end
  // next-state logic: FLUSH waits for the eof beat to leave, then resumes or idles
  always_comb begin
    state_next = state;
    nf_next    = nf;
    case (state)
      IDLE:   state_next = in_valid ? ACTIVE : IDLE;
      ACTIVE: if (in_valid && in_eof) begin
        state_next = FLUSH;
        nf_next    = 1'b0;
      end
      FLUSH: begin
        if (in_valid) nf_next = 1'b1;
        if (pop && head[0]) begin
          state_next = (nf || in_valid) ? ACTIVE : IDLE;
          nf_next    = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_conv_out_packer.sv
// tb_conv_out_packer: directed checks of saturation, raster tags, backpressure, flush FSM and reset
module tb_conv_out_packer;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [12:0] in_data = '0;
  logic out_valid, out_edge, out_eol, out_eof, overflow, frame_done, busy;
  logic [7:0] out_pixel;
  logic [10:0] q [$];
  int fd_cnt = 0, tests = 0, fails = 0;

  conv_out_packer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_edge(out_edge), .out_eol(out_eol), .out_eof(out_eof),
    .overflow(overflow), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // record every handshaken beat and every frame_done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (out_valid && out_ready) q.push_back({out_pixel, out_edge, out_eol, out_eof});
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 13'(v);
    step();
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int qb, fb, bad_pix, bad_eol, bad_eof, cnt, n;
    int sat_in  [6] = '{-4096, -256, -255, 31, 32, 4095};
    int sat_pix [6] = '{255, 255, 255, 31, 32, 255};
    int sat_edg [6] = '{1, 1, 1, 0, 1, 1};
    int bp_exp [13] = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12, 13, 14};

    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_fields", {out_pixel, out_edge, out_eol, out_eof}, 0);
    check("rst_flags", {overflow, frame_done, busy}, 0);
    reset = 1'b1;
    step();

    // full frame of +10 with constant ready
    do_reset();
    qb = q.size(); fb = fd_cnt;
    out_ready = 1'b1;
    send(10);
    check("busy_rise", busy, 1);
    for (int i = 1; i < 196; i++) send(10);
    in_valid = 1'b0;
    step();
    check("fd_early", frame_done, 0);
    step();
    check("fd_pulse", frame_done, 1);
    check("busy_fall", busy, 0);
    step();
    check("fd_width", frame_done, 0);
    drain(3);
    check("frame_beats", q.size() - qb, 196);
    bad_pix = 0; bad_eol = 0; bad_eof = 0;
    for (int i = 0; i < 196 && qb + i < q.size(); i++) begin
      if (q[qb+i][10:2] != {8'd10, 1'b0}) bad_pix++;
      if (q[qb+i][1] != (i % 14 == 13)) bad_eol++;
      if (q[qb+i][0] != (i == 195)) bad_eof++;
    end
    check("frame_pix", bad_pix, 0);
    check("frame_eol", bad_eol, 0);
    check("frame_eof", bad_eof, 0);
    check("frame_fd_cnt", fd_cnt - fb, 1);

    // saturation and sign handling
    do_reset();
    qb = q.size();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(sat_in[i]);
    drain(5);
    check("sat_beats", q.size() - qb, 6);
    for (int i = 0; i < 6 && qb + i < q.size(); i++) begin
      check($sformatf("sat_pix%0d", i), q[qb+i][10:3], sat_pix[i]);
      check($sformatf("sat_edge%0d", i), q[qb+i][2], sat_edg[i]);
    end

    // backpressure: fill, overflow on the 9th, dropped sample still advances col
    do_reset();
    qb = q.size();
    for (int v = 1; v <= 8; v++) send(v);
    in_valid = 1'b0;
    step();
    check("bp_valid", out_valid, 1);
    check("bp_no_ovf", overflow, 0);
    send(9);
    in_valid = 1'b0;
    step();
    check("bp_ovf", overflow, 1);
    out_ready = 1'b1;
    for (int v = 10; v <= 14; v++) send(v);
    drain(12);
    check("bp_beats", q.size() - qb, 13);
    bad_pix = 0; cnt = 0;
    for (int i = 0; i < 13 && qb + i < q.size(); i++) begin
      if (q[qb+i][10:3] != 8'(bp_exp[i])) bad_pix++;
      if (q[qb+i][1]) cnt++;
    end
    check("bp_order", bad_pix, 0);
    check("bp_eol_cnt", cnt, 1);
    if (qb + 12 < q.size()) check("bp_eol_last", q[qb+12][1], 1);
    check("bp_ovf_sticky", overflow, 1);

    // full FIFO with a push and a pop in the same cycle
    do_reset();
    qb = q.size();
    for (int v = 1; v <= 9; v++) send(v);
    out_ready = 1'b1;
    send(10);
    drain(12);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_beats", q.size() - qb, 10);
    bad_pix = 0;
    for (int i = 0; i < 10 && qb + i < q.size(); i++)
      if (q[qb+i][10:3] != 8'(i + 1)) bad_pix++;
    check("fullpop_order", bad_pix, 0);

    // two back-to-back frames with ready toggling
    do_reset();
    qb = q.size(); fb = fd_cnt; cnt = 0;
    for (int i = 0; i < 392; i++) begin
      out_ready = (i % 2 == 0);
      send(40);
      if (busy !== 1'b1) cnt++;
    end
    check("b2b_busy_held", cnt, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("b2b_drain_timeout", n < 200, 1);
    step();
    cnt = 0;
    for (int i = qb; i < q.size(); i++) if (q[i][0]) cnt++;
    check("b2b_eof_beats", cnt, 2);
    check("b2b_fd_cnt", fd_cnt - fb, 2);
    check("b2b_busy_low", busy, 0);

    // asynchronous reset mid-frame
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) send(100);
    in_valid = 1'b0;
    check("pre_rst_pix", out_pixel, 100);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_fields", {out_pixel, out_edge, out_eol, out_eof}, 0);
    check("arst_flags", {overflow, frame_done, busy}, 0);
    @(negedge clk);
    reset = 1'b1;
    qb = q.size();
    for (int i = 0; i < 14; i++) send(100);
    drain(5);
    check("arst_beats", q.size() - qb, 14);
    cnt = 0;
    for (int i = 0; i < 13 && qb + i < q.size(); i++) if (q[qb+i][1]) cnt++;
    check("arst_no_early_eol", cnt, 0);
    if (qb + 13 < q.size()) check("arst_eol14", q[qb+13][1], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
